// File: rtl/div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// The result and its destination register come back with a one-cycle ready_o pulse.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [2:0]  op_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        start_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic [4:0]  reg_waddr_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_END} state_e;

  state_e      state_q;
  logic        is_rem_q;
  logic [4:0]  waddr_q;
  logic [31:0] dvd_q;
  logic [31:0] dsr_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [4:0]  cnt_q;
  logic        qsign_q;
  logic        rsign_q;

  // Operand conditioning at issue
  logic        is_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] dz_res;

  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & dividend_i[31];
    b_neg     = is_signed & divisor_i[31];
    a_mag     = a_neg ? (~dividend_i + 32'd1) : dividend_i;
    b_mag     = b_neg ? (~divisor_i + 32'd1) : divisor_i;
    dz_res    = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract in 33 bits
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] fin_res;

  always_comb begin
    diff     = {rem_q, dvd_q[31]} - {1'b0, dsr_q};
    qbit     = ~diff[32];
    rem_step = qbit ? diff[31:0] : {rem_q[30:0], dvd_q[31]};
    quo_step = {quo_q[30:0], qbit};
    // The final step's results are signed here so result_o is already registered in END
    if (is_rem_q)
      fin_res = rsign_q ? (~rem_step + 32'd1) : rem_step;
    else
      fin_res = qsign_q ? (~quo_step + 32'd1) : quo_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_rem_q    <= 1'b0;
      waddr_q     <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      result_o    <= '0;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
      reg_waddr_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && op_i[2]) begin
            is_rem_q <= op_i[1];
            waddr_q  <= reg_waddr_i;
            dvd_q    <= a_mag;
            dsr_q    <= b_mag;
            qsign_q  <= a_neg ^ b_neg;
            rsign_q  <= a_neg;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            busy_o   <= 1'b1;
            if (divisor_i == 32'd0) begin
              state_q     <= S_END;
              result_o    <= dz_res;
              ready_o     <= 1'b1;
              reg_waddr_o <= reg_waddr_i;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          dvd_q <= {dvd_q[30:0], 1'b0};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q     <= S_END;
            result_o    <= fin_res;
            ready_o     <= 1'b1;
            reg_waddr_o <= waddr_q;
          end
        end
        S_END: begin
          state_q     <= S_IDLE;
          result_o    <= '0;
          ready_o     <= 1'b0;
          busy_o      <= 1'b0;
          reg_waddr_o <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
